// File: rtl/shift_left_seq.sv
// Sequential left shifter: shifts one bit per clock, pulses done on completion.
// Optional rotate mode enabled by defining SHIFT_LEFT_SEQ_ROTATE_EN.
module shift_left_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op,
   input  logic [SHW-1:0]   shamt,
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
   input  logic             rotate,
`endif
   output logic             ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             fill_bit;
   logic             accept;

`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
   logic rot_q, rot_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rot_q <= 1'b0;
      else        rot_q <= rot_d;
   end

   assign rot_d    = accept ? rotate : rot_q;
   // Rotation feeds the outgoing MSB back into the LSB.
   assign fill_bit = rot_q & work_q[WIDTH-1];
`else
   assign fill_bit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
      end
   end

   assign ready  = (state_q != SHIFT);
   assign accept = start & ready;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               work_d  = op;
               cnt_d   = shamt;
               carry_d = 1'b0;
               state_d = (shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            carry_d = work_q[WIDTH-1];
            work_d  = {work_q[WIDTH-2:0], fill_bit};
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign result = work_q;
   assign carry  = carry_q;
   assign zero   = (work_q == '0);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Randomized self-checking bench for shift_left_seq against an arithmetic model.
`timescale 1ns/1ps
module tb_shift_left_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] op;
   logic [2:0] shamt;
   logic       rot;
   logic       ready;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   shift_left_seq #(.WIDTH(8), .SHW(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .shamt  (shamt),
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
      .rotate (rot),
`endif
      .ready  (ready),
      .result (result),
      .carry  (carry),
      .zero   (zero),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_res(input logic [7:0] o, input int s, input bit r);
      logic [15:0] w;
      w = {8'h00, o} << s;
      if (r) return w[7:0] | w[15:8];
      return w[7:0];
   endfunction

   function automatic logic model_carry(input logic [7:0] o, input int s);
      if (s == 0) return 1'b0;
      return o[8-s];
   endfunction

   // Issue one operation and follow it to completion and one cycle beyond.
   task automatic run_op(input logic [7:0] o, input int s, input bit r, input bit inject);
      int lat;
      int busy;
      bit rr;
      logic [7:0] er;
      logic ec;
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
      rr = r;
`else
      rr = 1'b0;
`endif
      er = model_res(o, s, rr);
      ec = model_carry(o, s);
      start = 1'b1; op = o; shamt = 3'(s); rot = rr;
      @(posedge clk); #1;
      start = 1'b0;
      lat  = 1;
      busy = 0;
      while (!done && lat < 40) begin
         if (!ready) busy++;
         if (inject && lat == 3) begin
            start = 1'b1; op = 8'h01; shamt = 3'd2;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("latency", lat, s + 1);
      check("busy_cycles", busy, s);
      check("result", {24'h0, result}, {24'h0, er});
      check("carry", {31'h0, carry}, {31'h0, ec});
      check("zero", {31'h0, zero}, {31'h0, er == 8'h00});
      $display("op=%02h shamt=%0d rot=%0d -> result=%02h carry=%0d zero=%0d lat=%0d (exp %02h %0d)",
               o, s, rr, result, carry, zero, lat, er, ec);
      @(posedge clk); #1;
      check("done_single", {31'h0, done}, 32'h0);
      check("result_hold", {24'h0, result}, {24'h0, er});
      check("ready_idle", {31'h0, ready}, 32'h1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; shamt = '0; rot = 1'b0;
      #12;
      check("rst_result", {24'h0, result}, 32'h0);
      check("rst_carry", {31'h0, carry}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_ready", {31'h0, ready}, 32'h1);
      check("rst_zero", {31'h0, zero}, 32'h1);
      @(negedge clk); rst_n = 1'b1;

      // Directed cases; the first accept lands on the first edge after reset release.
      run_op(8'h0F, 1, 1'b0, 1'b0);
      run_op(8'hFF, 7, 1'b0, 1'b0);
      run_op(8'hA5, 0, 1'b0, 1'b0);
      run_op(8'h80, 1, 1'b0, 1'b0);
      run_op(8'hFF, 7, 1'b0, 1'b1);
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
      run_op(8'h81, 1, 1'b1, 1'b0);
      run_op(8'h81, 1, 1'b0, 1'b0);
      run_op(8'h96, 5, 1'b1, 1'b0);
`endif

      // Abort mid-shift with an asynchronous reset.
      start = 1'b1; op = 8'hFF; shamt = 3'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result", {24'h0, result}, 32'h0);
      check("abort_carry", {31'h0, carry}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_ready", {31'h0, ready}, 32'h1);
      check("abort_zero", {31'h0, zero}, 32'h1);
      @(posedge clk); #1;
      check("abort_no_done", {31'h0, done}, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      run_op(8'h03, 1, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SHW, default 3, giving the shift-amount width; SHW = clog2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port op, input, WIDTH bits: the operand, sampled on accept.
REQ-007 The block SHALL have port shamt, input, SHW bits: the shift amount, sampled on accept.
REQ-008 The block SHALL have port ready, output, 1 bit: high when start can be accepted.
REQ-009 The block SHALL have port result, output, WIDTH bits: the shifted value.
REQ-010 The block SHALL have port carry, output, 1 bit: the last bit shifted out of the MSB.
REQ-011 The block SHALL have port zero, output, 1 bit: high when result equals 0.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 ready SHALL be 1 in IDLE and DONE and 0 in SHIFT; accept = start & ready at a rising edge.
REQ-015 On accept, the block SHALL load op into the working register, load shamt into a down-counter and clear carry.
REQ-016 On accept with shamt != 0, the FSM SHALL go to SHIFT; with shamt = 0 it SHALL go directly to DONE, leaving result = op and carry = 0.
REQ-017 On each SHIFT cycle: carry <= reg[WIDTH-1], reg <= {reg[WIDTH-2:0], 1'b0}, counter decrements by 1; when the counter reaches 1 and is consumed, the FSM SHALL go to DONE.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle, first asserted shamt+1 clock edges after the accepting edge.
REQ-019 From DONE, the FSM SHALL go to IDLE, or back to SHIFT/DONE if start is accepted in the same cycle; done still pulses that cycle.
REQ-020 result, carry and zero SHALL hold their values from completion until the next accept.
REQ-021 result, carry and zero SHALL show intermediate values during SHIFT; consumers SHALL sample them only when done = 1.
REQ-022 start while ready = 0 SHALL be ignored, with no effect on the operation in flight.
REQ-023 zero SHALL be combinational from result.

Reset
REQ-024 When rst_n = 0, the block SHALL immediately force state = IDLE, result = 0, carry = 0, counter = 0 and done = 0, independent of clk.
REQ-025 After reset, ready = 1 and zero = 1.
REQ-026 Reset asserted during SHIFT SHALL abort the operation, and no done pulse SHALL follow.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 When macro SHIFT_LEFT_SEQ_ROTATE_EN is defined, the block SHALL add input port rotate (1 bit), sampled and held on accept.
REQ-029 When rotate = 1, each SHIFT cycle SHALL perform reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}; carry SHALL be updated as in REQ-017.
REQ-030 When the macro is undefined, port rotate SHALL be absent and the shift SHALL always be logical with zero fill.

Verification
REQ-031 op=8'h0F, shamt=1, start -> done 2 cycles later, result=8'h1E, carry=0, zero=0.
REQ-032 op=8'hFF, shamt=7 -> done 8 cycles after accept, result=8'h80, carry=1; ready=0 for 7 cycles.
REQ-033 op=8'hA5, shamt=0 -> done 1 cycle later, result=8'hA5, carry=0; op=8'h80, shamt=1 -> result=8'h00, carry=1, zero=1.
REQ-034 start with op=8'h01, shamt=2 issued during a 7-cycle SHIFT -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-035 rst_n pulsed low mid-SHIFT -> outputs immediately 0, no done pulse, and the next op=8'h03, shamt=1 -> result=8'h06.
REQ-036 With SHIFT_LEFT_SEQ_ROTATE_EN defined: op=8'h81, shamt=1, rotate=1 -> result=8'h03, carry=1; with rotate=0 -> result=8'h02, carry=1.
